bus_write: RTL and testbench

//  Transmit side of the PE-to-PE shared bus. Buffers words a PE wants to send, wins the bus
//  via a req/gnt handshake with the bus arbiter, drives {data,addr,valid} beats (addr = own
//  PE_NO as source tag, matching the receiver's per-source FIFO indexing), honours receiver

---
 rtl/bus_write_pkg.sv | 21 ++
 rtl/fifo_bus_write.sv | 56 +++++
 rtl/bus_write.sv | 129 ++++++++++++
 tb/tb_bus_write.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bus_write_pkg.sv
// Shared definitions for the PE bus transmit path: FSM encodings, default widths, log2 helper.
package bus_write_pkg;

  localparam logic [1:0] BW_IDLE = 2'd0;
  localparam logic [1:0] BW_REQ  = 2'd1;
  localparam logic [1:0] BW_XMIT = 2'd2;

  localparam int DEF_DATA_LEN     = 16;
  localparam int DEF_BUS_ADDR_LEN = 3;

  // Bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int c_log_2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_bus_write.sv
// TX word buffer: first-word-fall-through sync FIFO, count-based full/empty, 1-cycle write latency.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module fifo_bus_write
  import bus_write_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [DATA_LEN-1:0] head,
  output logic                full,
  output logic                empty
);

  localparam int PW = c_log_2(FIFO_DEPTH);
  localparam int CW = c_log_2(FIFO_DEPTH + 1);

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_write.sv
// PE bus transmitter: buffers PE words, requests the bus, sends up to MAX_BURST beats per grant
// (push->req 1 cycle, push->beat 2 cycles); stall/bus_full pause beats. BUS_WRITE_PERF_EN adds perf counters.
module bus_write
  import bus_write_pkg::*;
#(
  parameter int DATA_LEN     = DEF_DATA_LEN,
  parameter int BUS_ADDR_LEN = DEF_BUS_ADDR_LEN,
  parameter int PE_NO        = 0,
  parameter int NUM_ELEM     = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    stall,
  input  logic [DATA_LEN-1:0]     dst_data_in,
  input  logic                    dst_wr_in,
  output logic                    wr_buffer_full,
  output logic                    tx_overflow,
  output logic                    bus_req,
  input  logic                    bus_gnt,
  input  logic                    bus_full,
  output logic [DATA_LEN-1:0]     data_to_bus,
  output logic [BUS_ADDR_LEN-1:0] addr_to_bus,
  output logic                    valid_to_bus
`ifdef BUS_WRITE_PERF_EN
  ,
  output logic [31:0]             perf_beats,
  output logic [31:0]             perf_bp_cycles
`endif
);

  localparam int BW = c_log_2(MAX_BURST + 1);
  localparam logic [BW-1:0]           BURST_MAX = BW'(MAX_BURST);
  localparam logic [BUS_ADDR_LEN-1:0] SRC_TAG   = BUS_ADDR_LEN'(PE_NO % NUM_ELEM);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [BW-1:0]       burst_cnt;
  logic [DATA_LEN-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                can_beat;
  logic                burst_room;
  logic                issue;

  fifo_bus_write #(
    .DATA_LEN  (DATA_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (dst_wr_in),
    .push_data(dst_data_in),
    .pop      (issue),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_buffer_full = fifo_full;
  assign can_beat       = bus_gnt && !stall && !bus_full && !fifo_empty;
  assign burst_room     = (burst_cnt < BURST_MAX);

  always_comb begin
    issue     = 1'b0;
    state_nxt = state;
    case (state)
      BW_IDLE: begin
        if (!fifo_empty) state_nxt = BW_REQ;
      end
      BW_REQ: begin
        if (can_beat) begin
          issue     = 1'b1;
          state_nxt = BW_XMIT;
        end
      end
      BW_XMIT: begin
        // Pause (grant kept, room left) or lost grant keeps the request; an exhausted burst yields.
        if (can_beat && burst_room) begin
          issue = 1'b1;
        end else if (!fifo_empty && (!bus_gnt || burst_room)) begin
          state_nxt = BW_REQ;
        end else begin
          state_nxt = BW_IDLE;
        end
      end
      default: state_nxt = BW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= BW_IDLE;
      burst_cnt    <= '0;
      bus_req      <= 1'b0;
      valid_to_bus <= 1'b0;
      data_to_bus  <= '0;
      addr_to_bus  <= '0;
      tx_overflow  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus_req      <= (state_nxt != BW_IDLE);
      valid_to_bus <= issue;
      if (issue) begin
        data_to_bus <= fifo_head;
        addr_to_bus <= SRC_TAG;
        burst_cnt   <= (state == BW_XMIT) ? burst_cnt + 1'b1 : BW'(1);
      end
      if (dst_wr_in && fifo_full && !issue) tx_overflow <= 1'b1;
    end
  end

`ifdef BUS_WRITE_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_beats     <= '0;
      perf_bp_cycles <= '0;
    end else begin
      if (issue && (perf_beats != 32'hFFFF_FFFF)) perf_beats <= perf_beats + 32'd1;
      if ((state != BW_IDLE) && bus_gnt && bus_full && (perf_bp_cycles != 32'hFFFF_FFFF))
        perf_bp_cycles <= perf_bp_cycles + 32'd1;
    end
  end
`else
  // Counters are not built in the default configuration.
`endif

endmodule

// File: tb/tb_bus_write.sv
// Directed bench for bus_write: per-scenario tasks drive cycle masks and check captured outputs.
module tb_bus_write;

  localparam int DL = 16;
  localparam int AL = 3;
  localparam int PE = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          stall;
  logic [DL-1:0] dst_data_in;
  logic          dst_wr_in;
  logic          wr_buffer_full;
  logic          tx_overflow;
  logic          bus_req;
  logic          bus_gnt;
  logic          bus_full;
  logic [DL-1:0] data_to_bus;
  logic [AL-1:0] addr_to_bus;
  logic          valid_to_bus;
`ifdef BUS_WRITE_PERF_EN
  logic [31:0]   perf_beats;
  logic [31:0]   perf_bp_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   vmask, rmask, fmask, omask;
  logic [DL-1:0] got_q [$];
  logic [AL-1:0] addr_q [$];

  bus_write #(
    .DATA_LEN(DL), .BUS_ADDR_LEN(AL), .PE_NO(PE), .NUM_ELEM(8), .FIFO_DEPTH(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .dst_data_in(dst_data_in), .dst_wr_in(dst_wr_in),
    .wr_buffer_full(wr_buffer_full), .tx_overflow(tx_overflow), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .bus_full(bus_full), .data_to_bus(data_to_bus),
    .addr_to_bus(addr_to_bus), .valid_to_bus(valid_to_bus)
`ifdef BUS_WRITE_PERF_EN
    , .perf_beats(perf_beats), .perf_bp_cycles(perf_bp_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Bit k of each mask is the input applied at edge k; outputs are sampled on the following negedge.
  task automatic run_vec(input int n, input logic [31:0] push_m, input logic [31:0] full_m,
                         input logic [31:0] stall_m, input logic [31:0] gnt_m, input logic [DL-1:0] base);
    logic [DL-1:0] w;
    w = base;
    vmask = '0; rmask = '0; fmask = '0; omask = '0;
    got_q.delete();
    addr_q.delete();
    for (int k = 0; k < n; k++) begin
      dst_wr_in   = push_m[k];
      dst_data_in = w;
      if (push_m[k]) w = w + 1'b1;
      bus_full    = full_m[k];
      stall       = stall_m[k];
      bus_gnt     = gnt_m[k];
      @(posedge clk);
      @(negedge clk);
      vmask[k] = valid_to_bus;
      rmask[k] = bus_req;
      fmask[k] = wr_buffer_full;
      omask[k] = tx_overflow;
      if (valid_to_bus) begin
        got_q.push_back(data_to_bus);
        addr_q.push_back(addr_to_bus);
      end
    end
    dst_wr_in = 1'b0;
    bus_full  = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; stall = 1'b0; dst_wr_in = 1'b0; dst_data_in = '0; bus_gnt = 1'b0; bus_full = 1'b0;
    #12;
    n_cmp++; if ({bus_req, valid_to_bus, wr_buffer_full, tx_overflow} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus_req, valid_to_bus, wr_buffer_full, tx_overflow});
    end
    n_cmp++; if ({data_to_bus, addr_to_bus} !== '0) begin
      n_bad++; $display("FAIL reset_bus: got data %h addr %0d want 0/0", data_to_bus, addr_to_bus);
    end
`ifdef BUS_WRITE_PERF_EN
    n_cmp++; if ({perf_beats, perf_bp_cycles} !== 64'd0) begin
      n_bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_beats, perf_bp_cycles);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    run_vec(6, 32'h1, 32'h0, 32'h0, '1, 16'h1234);
    n_cmp++; if (vmask !== 32'h4) begin n_bad++; $display("FAIL single_valid: got %h want %h", vmask, 32'h4); end
    n_cmp++; if (rmask !== 32'h6) begin n_bad++; $display("FAIL single_req: got %h want %h", rmask, 32'h6); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 16'h1234 || addr_q[0] !== 3'(PE)) begin
      n_bad++; $display("FAIL single_beat: got %0d beats first %h/%0d want 1 beat 1234/%0d",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0, (addr_q.size() > 0) ? addr_q[0] : 3'd0, PE);
    end
  endtask

  task automatic test_burst();
    run_vec(12, 32'h3F, 32'h0, 32'h0, '1, 16'hA000);
    n_cmp++; if (vmask !== 32'h33C) begin n_bad++; $display("FAIL burst_valid: got %h want %h", vmask, 32'h33C); end
    n_cmp++; if (rmask !== 32'h3BE) begin n_bad++; $display("FAIL burst_req: got %h want %h", rmask, 32'h3BE); end
    n_cmp++; if (got_q.size() != 6) begin n_bad++; $display("FAIL burst_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== 16'hA000 + 16'(i)) begin
        n_bad++; $display("FAIL burst_data%0d: got %h want %h", i, got_q[i], 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    run_vec(12, 32'h7, 32'hF8, 32'h0, '1, 16'h3000);
    n_cmp++; if (vmask !== 32'h304) begin n_bad++; $display("FAIL bp_valid: got %h want %h", vmask, 32'h304); end
    n_cmp++; if (rmask !== 32'h3FE) begin n_bad++; $display("FAIL bp_req: got %h want %h", rmask, 32'h3FE); end
    n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== 16'h3000 + 16'(i)) begin
        n_bad++; $display("FAIL bp_data%0d: got %h want %h", i, got_q[i], 16'h3000 + 16'(i));
      end
    end
`ifdef BUS_WRITE_PERF_EN
    n_cmp++; if (perf_bp_cycles !== 32'd5) begin n_bad++; $display("FAIL bp_perf: got %0d want 5", perf_bp_cycles); end
`endif
  endtask

  task automatic test_overflow();
    run_vec(10, 32'h1FF, 32'h0, 32'h0, 32'h0, 16'hC000);
    n_cmp++; if (fmask !== 32'h380) begin n_bad++; $display("FAIL ovf_full: got %h want %h", fmask, 32'h380); end
    n_cmp++; if (omask !== 32'h300) begin n_bad++; $display("FAIL ovf_sticky: got %h want %h", omask, 32'h300); end
    n_cmp++; if (vmask !== 32'h0) begin n_bad++; $display("FAIL ovf_valid: got %h want 0", vmask); end
    n_cmp++; if (rmask !== 32'h3FE) begin n_bad++; $display("FAIL ovf_req: got %h want %h", rmask, 32'h3FE); end
  endtask

  task automatic test_reset_mid_burst();
    run_vec(3, 32'h0, 32'h0, 32'h0, '1, 16'h0);
    n_cmp++; if (vmask !== 32'h7 || rmask !== 32'h7 || omask !== 32'h7) begin
      n_bad++; $display("FAIL mid_pre: got v%h r%h o%h want 7/7/7", vmask, rmask, omask);
    end
    n_cmp++; if (got_q.size() != 3 || got_q[0] !== 16'hC000 || got_q[2] !== 16'hC002) begin
      n_bad++; $display("FAIL mid_data: got %0d beats want 3 (C000..C002)", got_q.size());
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if ({bus_req, valid_to_bus, tx_overflow, wr_buffer_full} !== 4'b0) begin
      n_bad++; $display("FAIL mid_async: got %b want 0000", {bus_req, valid_to_bus, tx_overflow, wr_buffer_full});
    end
    @(negedge clk);
    rstn = 1'b1;
    run_vec(8, 32'h0, 32'h0, 32'h0, '1, 16'h0);
    n_cmp++; if (vmask !== 32'h0 || rmask !== 32'h0 || fmask !== 32'h0) begin
      n_bad++; $display("FAIL mid_after: got v%h r%h f%h want 0/0/0", vmask, rmask, fmask);
    end
  endtask

  task automatic test_stall();
    run_vec(10, 32'h3, 32'h0, 32'h3F, '1, 16'h5A00);
    n_cmp++; if (vmask !== 32'hC0) begin n_bad++; $display("FAIL stall_valid: got %h want %h", vmask, 32'hC0); end
    n_cmp++; if (rmask !== 32'hFE) begin n_bad++; $display("FAIL stall_req: got %h want %h", rmask, 32'hFE); end
    n_cmp++; if (got_q.size() != 2 || got_q[0] !== 16'h5A00 || got_q[1] !== 16'h5A01) begin
      n_bad++; $display("FAIL stall_data: got %0d beats want 2 (5A00,5A01)", got_q.size());
    end
`ifdef BUS_WRITE_PERF_EN
    n_cmp++; if (perf_beats !== 32'd2) begin n_bad++; $display("FAIL stall_perf: got %0d want 2", perf_beats); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_reset_mid_burst();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
